// File: rtl/decoder_input_frontend.sv
// Serial capture front end for the decoder.
// Synchronises a three-wire serial link (cs_n, sck, sdi), frames 7-bit words, checks the
// bit count (and optional odd parity), and presents good words through a one-entry
// valid/ready holding register. Rejected frames bump a saturating counter; good frames
// that find the holding register full set a sticky overrun flag.
// Optional feature: define DECODER_FE_PARITY_EN to append and check an odd parity bit.
module decoder_input_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 ser_cs_n,
  input  logic                 ser_sck,
  input  logic                 ser_sdi,
  output logic [6:0]           code_out,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  input  logic                 err_clr
);

`ifdef DECODER_FE_PARITY_EN
  localparam int unsigned FRAME_BITS = 8;
`else
  localparam int unsigned FRAME_BITS = 7;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sdi_sync_q;
  logic                   cs_d1_q, sck_d1_q;
  logic                   cs_s, sck_s, sdi_s;
  logic                   cs_fall, cs_rise, sck_rise;

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  shreg_q;
  logic [3:0]             bitcnt_q;

  logic [6:0]             code_q, code_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

  logic                   parity_ok;
  logic                   frame_good, frame_bad;
  logic                   load, drop, xfer;
  logic [6:0]             frame_data;

  // Pin synchronisers plus one delay flop on cs_n/sck for edge detection.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '1;
      sdi_sync_q <= '0;
      cs_d1_q    <= 1'b1;
      sck_d1_q   <= 1'b1;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], ser_cs_n};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], ser_sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], ser_sdi};
      cs_d1_q    <= cs_s;
      sck_d1_q   <= sck_s;
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_d1_q & ~cs_s;
  assign cs_rise  = ~cs_d1_q & cs_s;
  assign sck_rise = ~sck_d1_q & sck_s;

  // Framing FSM: collect bits between cs_n edges, then spend one cycle checking.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          shreg_q  <= '0;
          bitcnt_q <= '0;
          if (cs_fall) state_q <= StShift;
        end
        StShift: begin
          if (cs_rise) begin
            // An sck edge coincident with frame end is ignored.
            state_q <= StCheck;
          end else if (sck_rise) begin
            shreg_q <= {shreg_q[FRAME_BITS-2:0], sdi_s};
            if (bitcnt_q != 4'd15) bitcnt_q <= bitcnt_q + 4'd1;
          end
        end
        StCheck: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DECODER_FE_PARITY_EN
  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign parity_ok = ^shreg_q;
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_data = shreg_q[FRAME_BITS-1 -: 7];
  assign frame_good = (state_q == StCheck) && (bitcnt_q == 4'(FRAME_BITS)) && parity_ok;
  assign frame_bad  = (state_q == StCheck) && !frame_good;

  // Holding register, overrun flag and error counter next state; err_clr wins.
  always_comb begin
    xfer    = valid_q && code_ready;
    load    = frame_good && (!valid_q || code_ready);
    drop    = frame_good && !load;
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (load) begin
      code_d  = frame_data;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (err_clr) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (drop) ovr_d = 1'b1;
      if (frame_bad && (cnt_q != {ERR_CNT_W{1'b1}})) cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  // Output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign code_out      = code_q;
  assign code_valid    = valid_q;
  assign overrun       = ovr_q;
  assign frame_err_cnt = cnt_q;

endmodule

// File: tb/tb_decoder_input_frontend.sv
// Directed, table-driven bench for decoder_input_frontend.
module tb_decoder_input_frontend;

`ifdef DECODER_FE_PARITY_EN
  localparam int FB = 8;
`else
  localparam int FB = 7;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n, sck, sdi;
  logic [6:0] code_out;
  logic       code_valid, code_ready, overrun, err_clr;
  logic [7:0] err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  decoder_input_frontend #(.SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .ser_cs_n     (cs_n),
    .ser_sck      (sck),
    .ser_sdi      (sdi),
    .code_out     (code_out),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .overrun      (overrun),
    .frame_err_cnt(err_cnt),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] word;
    int         nbits;
    bit         good;
    bit         ready;
    bit         exp_v;
    logic [6:0] exp_code;
    bit         exp_ovr;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Good data word framed for this build (odd parity appended when enabled).
  function automatic logic [15:0] mk(input logic [6:0] d);
`ifdef DECODER_FE_PARITY_EN
    return {8'b0, d, ~^d};
`else
    return {9'b0, d};
`endif
  endfunction

  // One frame, MSB first; returns right after cs_n rises.
  task automatic send(input logic [15:0] w, input int n);
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      sdi = w[n-1-i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    tick(4);
    cs_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    tbl[0] = '{9'b000000001, 7, 1'b1, 1'b0, 1'b1, 7'b0000001, 1'b0, 0};
    tbl[1] = '{9'b001111111, 7, 1'b1, 1'b0, 1'b1, 7'b0000001, 1'b1, 0};
    tbl[2] = '{9'b000101101, 6, 1'b0, 1'b0, 1'b1, 7'b0000001, 1'b1, 1};
    tbl[3] = '{9'b101101101, 9, 1'b0, 1'b0, 1'b1, 7'b0000001, 1'b1, 2};
    tbl[4] = '{9'b001100110, 7, 1'b1, 1'b1, 1'b0, 7'b1100110, 1'b1, 2};
    tbl[5] = '{9'b000000000, 0, 1'b0, 1'b0, 1'b0, 7'b1100110, 1'b1, 3};
    tbl[6] = '{9'b000110011, 7, 1'b1, 1'b0, 1'b1, 7'b0110011, 1'b1, 3};

    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0; code_ready = 1'b0; err_clr = 1'b0;
    tick(3);
    check("rst code_out", 32'(code_out), 0);
    check("rst code_valid", 32'(code_valid), 0);
    check("rst overrun", 32'(overrun), 0);
    check("rst err_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    tick(3);

    // First frame with ready held: valid appears 4 cycles after cs_n rise for one cycle.
    code_ready = 1'b1;
    send(mk(7'b1011000), FB);
    tick(3);
    check("t1 valid early", 32'(code_valid), 0);
    tick(1);
    check("t1 valid", 32'(code_valid), 1);
    check("t1 code", 32'(code_out), 32'(7'b1011000));
    tick(1);
    check("t1 valid pulse", 32'(code_valid), 0);
    check("t1 errcnt", 32'(err_cnt), 0);
    check("t1 overrun", 32'(overrun), 0);
    tick(3);

    for (int i = 0; i < 7; i++) begin
      code_ready = tbl[i].ready;
      w = tbl[i].good ? mk(tbl[i].word[6:0]) : 16'(tbl[i].word);
      send(w, tbl[i].good ? FB : tbl[i].nbits);
      tick(6);
      check($sformatf("vec%0d valid", i), 32'(code_valid), 32'(tbl[i].exp_v));
      check($sformatf("vec%0d code", i), 32'(code_out), 32'(tbl[i].exp_code));
      check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
      check($sformatf("vec%0d errcnt", i), 32'(err_cnt), 32'(tbl[i].exp_cnt));
    end

    // Single-cycle ready drains the held word.
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    check("drain valid", 32'(code_valid), 0);
    check("drain code", 32'(code_out), 32'(7'b0110011));
    tick(2);

`ifdef DECODER_FE_PARITY_EN
    send({8'b0, 7'b1011000, 1'b1}, 8);
    tick(6);
    check("par bad errcnt", 32'(err_cnt), 4);
    check("par bad valid", 32'(code_valid), 0);
    send({8'b0, 7'b1011000, 1'b0}, 8);
    tick(6);
    check("par good valid", 32'(code_valid), 1);
    check("par good code", 32'(code_out), 32'(7'b1011000));
    check("par good errcnt", 32'(err_cnt), 4);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    tick(2);
`endif

    // Counter saturation, then clear racing a bad-frame check.
    for (int i = 0; i < 300; i++) begin
      send(16'h0, 0);
      tick(6);
    end
    check("sat errcnt", 32'(err_cnt), 255);
    send(16'h0, 0);
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("clr errcnt", 32'(err_cnt), 0);
    check("clr overrun", 32'(overrun), 0);
    tick(2);
    check("clr errcnt hold", 32'(err_cnt), 0);

    // Populate every output, then reset mid-frame.
    send(mk(7'b0011001), FB);
    tick(6);
    check("pre valid", 32'(code_valid), 1);
    send(16'b101, 3);
    tick(6);
    check("pre errcnt", 32'(err_cnt), 1);
    send(mk(7'b1110000), FB);
    tick(6);
    check("pre overrun", 32'(overrun), 1);
    check("pre code", 32'(code_out), 32'(7'b0011001));

    cs_n = 1'b0;
    tick(4);
    w = mk(7'b0101010);
    for (int i = 0; i < 4; i++) begin
      sdi = w[FB-1-i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    rst = 1'b1;
    #2;
    check("mid rst code", 32'(code_out), 0);
    check("mid rst valid", 32'(code_valid), 0);
    check("mid rst overrun", 32'(overrun), 0);
    check("mid rst errcnt", 32'(err_cnt), 0);
    cs_n = 1'b1;
    sck = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    code_ready = 1'b1;
    send(mk(7'b0101010), FB);
    tick(3);
    check("post rst valid early", 32'(code_valid), 0);
    tick(1);
    check("post rst valid", 32'(code_valid), 1);
    check("post rst code", 32'(code_out), 32'(7'b0101010));
    check("post rst errcnt", 32'(err_cnt), 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_input_frontend.md
# decoder_input_frontend

Upstream capture stage for the decoder: receives 7-bit code words over a three-wire serial pin interface (chip-select, shift clock, data), oversamples and synchronises the pins in the system clock domain, frames and checks each word, and presents it to the decoder's 7-bit `io_in` through a one-entry valid/ready holding register. It replaces direct pad drive of the decoder input with a glitch-free, handshaked word stream and sticky error reporting.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per serial pin (legal 2..3).
- `ERR_CNT_W`, default 8: width of the saturating frame-error counter.
- `wb_clk_i  in  1` — system clock; all logic on the rising edge.
- `wb_rst_i  in  1` — reset, asynchronous assert, active-high; deassertion is synchronous to `wb_clk_i` upstream.
- `ser_cs_n  in  1` — frame select, active-low, asynchronous to `wb_clk_i`.
- `ser_sck  in  1` — shift clock, asynchronous; data sampled on its synchronised rising edge.
- `ser_sdi  in  1` — serial data, MSB first.
- `code_out  out  7` — captured word, drives decoder `io_in`.
- `code_valid  out  1` — `code_out` holds an unconsumed word.
- `code_ready  in  1` — decoder accepts the word this cycle.
- `overrun  out  1` — sticky: a good frame was dropped because the holding register was full.
- `frame_err_cnt  out  ERR_CNT_W` — count of rejected frames, saturating.
- `err_clr  in  1` — single-cycle pulse clearing `overrun` and `frame_err_cnt`.

## Operation
- Synchroniser: each of `ser_cs_n`, `ser_sck`, `ser_sdi` passes through `SYNC_STAGES` flops. Reset value: `ser_cs_n` and `ser_sck` chains 1, `ser_sdi` chain 0. One extra flop on the synchronised `ser_sck` and `ser_cs_n` provides edge detection.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: shift register and bit counter cleared. Synchronised `cs_n` falling edge → SHIFT.
  - SHIFT: each synchronised `sck` rising edge shifts `sdi` into the LSB and increments the 4-bit bit counter. The counter saturates at 15. Synchronised `cs_n` rising edge → CHECK.
  - CHECK (one cycle): a frame is good when the bit count equals `FRAME_BITS` (7, or 8 with parity) and, with parity enabled, the parity check passes. Always → IDLE.
- Good frame:
  - If `code_valid`=0, or `code_valid`=1 and `code_ready`=1 in the CHECK cycle, the 7 data bits (bits [FRAME_BITS-1 : FRAME_BITS-7] of the shift register) load `code_out` and `code_valid`=1.
  - Otherwise the frame is dropped, `overrun` is set and `code_out` is unchanged.
- Bad frame: `frame_err_cnt` increments and saturates at all-ones. The holding register is untouched.
- Handshake: a transfer occurs when `code_valid` and `code_ready` are both 1. After a transfer `code_valid` falls unless a load happens in the same cycle. `code_out` is stable while `code_valid`=1.
- `err_clr` has priority over a same-cycle set or increment: the result is 0.
- A `sck` edge in the same cycle as the `cs_n` rising edge is ignored.

## Timing
- Reset values: `code_out`=0, `code_valid`=0, `overrun`=0, `frame_err_cnt`=0, FSM=IDLE.
- Latency: `code_valid` rises `SYNC_STAGES`+2 cycles after the `ser_cs_n` rising edge at the pin: sync, edge detect, CHECK, register.
- Serial constraint: `ser_sck` high and low times are each at least `SYNC_STAGES`+1 system cycles. Faster shifting is out of spec and yields a bad bit count.
- Reset mid-frame aborts the frame silently. No error is counted, and the first frame after reset starts at the next `cs_n` fall.
- Throughput: one word per frame. The holding register is the only buffering.

## Configuration
- `DECODER_FE_PARITY_EN` defined: `FRAME_BITS`=8. The eighth bit, last shifted, is odd parity over the 7 data bits. A parity mismatch is a bad frame.
- Undefined: `FRAME_BITS`=7, no parity logic, and bad frames arise only from a wrong bit count.

## Test plan
- Reset, then a frame `1011000` with `code_ready`=1 (parity bit 0 when enabled) → `code_out`=7'b1011000, `code_valid` pulses for 1 cycle, no errors.
- Two good frames `0000001` then `1111111` with `code_ready`=0 → `code_out` stays `0000001` and `overrun`=1. Then raise `code_ready` → one transfer, and `code_valid` drops.
- Frame of 6 bits → `frame_err_cnt`=1 and `code_valid` stays 0. Then a frame of 9 bits → `frame_err_cnt`=2.
- Parity build: `1011000` with parity bit 1 → counted as an error. With parity bit 0 → accepted.
- 300 short frames with `ERR_CNT_W`=8 → `frame_err_cnt` holds 255. Then `err_clr` pulsed in the same cycle as a bad-frame CHECK → counter reads 0.
- Assert `wb_rst_i` after 4 bits of a frame → all outputs return to reset values immediately. A following complete frame `0101010` is accepted.
